// File: rtl/sdram_bist_gen.sv
// SDRAM BIST traffic generator/checker: write pattern, wait, read back, compare.
// Build option: SDRAM_BIST_PRBS_EN selects LFSR patterns instead of incrementing data.
module sdram_bist_gen #(
    parameter int NUM_WORDS = 1024,
    parameter int RD_DELAY  = 2000
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic        sdram_init_done,
    output logic        wr_en,
    output logic [15:0] wr_data,
    output logic        rd_en,
    input  logic [15:0] rd_data,
    output logic        test_done,
    output logic        error_flag,
    output logic [15:0] err_cnt,
    output logic [15:0] first_err_idx
);

    typedef enum logic [2:0] {
        IDLE, WR, WAIT, RD, FLUSH, DONE
    } state_t;

    localparam logic [15:0] NW_LAST  = 16'(NUM_WORDS - 1);
    localparam logic [15:0] DLY_LAST = 16'((RD_DELAY == 0) ? 0 : RD_DELAY - 1);

    state_t      state, state_nx;
    logic        sync1, init_s;
    logic [15:0] wr_idx, rd_idx, cmp_idx, dly_cnt;
    logic        rd_en_d1;
    logic [15:0] pat_w, pat_r;
    logic        abort, wr_load, rd_load, wr_step, cmp_v, mism;

    // two-flop synchroniser for the controller's init flag
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            init_s <= 1'b0;
        end else begin
            sync1  <= sdram_init_done;
            init_s <= sync1;
        end
    end

    // state register
    always_ff @(posedge clk_50m) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state logic and per-cycle control strobes
    always_comb begin
        state_nx = state;
        abort    = 1'b0;
        unique case (state)
            IDLE:  if (init_s) state_nx = WR;
            WR: begin
                if (!init_s) begin
                    state_nx = IDLE;
                    abort    = 1'b1;
                end else if (wr_idx == NW_LAST) begin
                    state_nx = (RD_DELAY == 0) ? RD : WAIT;
                end
            end
            WAIT: begin
                if (!init_s) begin
                    state_nx = IDLE;
                    abort    = 1'b1;
                end else if (dly_cnt == DLY_LAST) begin
                    state_nx = RD;
                end
            end
            RD: begin
                if (!init_s) begin
                    state_nx = IDLE;
                    abort    = 1'b1;
                end else if (rd_idx == NW_LAST) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (!init_s) begin
                    state_nx = IDLE;
                    abort    = 1'b1;
                end else begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        wr_load = (state == IDLE) && init_s;
        rd_load = (state_nx == RD) && (state != RD);
        wr_step = (state == WR) && !abort;
        cmp_v   = rd_en_d1 && !abort;
        mism    = cmp_v && (rd_data != pat_r);
    end

`ifdef SDRAM_BIST_PRBS_EN
    logic [15:0] wr_lfsr, rd_lfsr;

    function automatic logic [15:0] lfsr_nx(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    assign pat_w = wr_lfsr;
    assign pat_r = rd_lfsr;

    // write/read pattern LFSRs, reseeded on entry to their phase
    always_ff @(posedge clk_50m) begin
        if (!rst_n || abort) begin
            wr_lfsr <= 16'hACE1;
            rd_lfsr <= 16'hACE1;
        end else begin
            if (wr_load)      wr_lfsr <= 16'hACE1;
            else if (wr_step) wr_lfsr <= lfsr_nx(wr_lfsr);
            if (rd_load)      rd_lfsr <= 16'hACE1;
            else if (cmp_v)   rd_lfsr <= lfsr_nx(rd_lfsr);
        end
    end
`else
    assign pat_w = wr_idx;
    assign pat_r = cmp_idx;
`endif

    // registered traffic outputs, counters and sticky status
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            wr_en         <= 1'b0;
            wr_data       <= 16'd0;
            rd_en         <= 1'b0;
            rd_en_d1      <= 1'b0;
            wr_idx        <= 16'd0;
            rd_idx        <= 16'd0;
            cmp_idx       <= 16'd0;
            dly_cnt       <= 16'd0;
            test_done     <= 1'b0;
            error_flag    <= 1'b0;
            err_cnt       <= 16'd0;
            first_err_idx <= 16'd0;
        end else if (abort) begin
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
            rd_en_d1 <= 1'b0;
            wr_idx   <= 16'd0;
            rd_idx   <= 16'd0;
            cmp_idx  <= 16'd0;
            dly_cnt  <= 16'd0;
        end else begin
            wr_en     <= wr_step;
            rd_en     <= (state == RD);
            rd_en_d1  <= rd_en;
            test_done <= (state == DONE);
            if (wr_step) begin
                wr_data <= pat_w;
                wr_idx  <= (wr_idx == NW_LAST) ? 16'd0 : wr_idx + 16'd1;
            end
            if (state == WAIT)
                dly_cnt <= (dly_cnt == DLY_LAST) ? 16'd0 : dly_cnt + 16'd1;
            if (state == RD)
                rd_idx <= (rd_idx == NW_LAST) ? 16'd0 : rd_idx + 16'd1;
            if (cmp_v)
                cmp_idx <= cmp_idx + 16'd1;
            if (mism) begin
                error_flag <= 1'b1;
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (!error_flag) first_err_idx <= cmp_idx;
            end
            if (rd_load) cmp_idx <= 16'd0;
        end
    end

endmodule

// File: tb/tb_sdram_bist_gen.sv
// Directed bench for sdram_bist_gen with a loopback FIFO model.
// Covers clean, corrupted, abort/restart and mid-read reset scenarios.
module tb_sdram_bist_gen;

    localparam int NW  = 8;
    localparam int DLY = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_done;
    logic        wr_en, rd_en, test_done, error_flag;
    logic [15:0] wr_data, rd_data, err_cnt, first_err_idx;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int mode = 0;
    logic model_clr;

    logic [15:0] mem [0:NW-1];
    int wptr, rptr;
    logic [15:0] wr_log [$];
    int wr_cyc [$];
    int rd_cyc [$];

    sdram_bist_gen #(.NUM_WORDS(NW), .RD_DELAY(DLY)) dut (
        .clk_50m(clk),
        .rst_n(rst_n),
        .sdram_init_done(init_done),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .test_done(test_done),
        .error_flag(error_flag),
        .err_cnt(err_cnt),
        .first_err_idx(first_err_idx)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // loopback FIFO, optional corruption of returned words
    always @(posedge clk) begin
        if (model_clr) begin
            wptr <= 0;
            rptr <= 0;
        end else begin
            if (wr_en) begin
                mem[wptr % NW] <= wr_data;
                wptr <= wptr + 1;
            end
            if (rd_en) begin
                if (mode == 2)
                    rd_data <= 16'hFFFF;
                else if (mode == 1 && rptr == 5)
                    rd_data <= 16'hDEAD;
                else
                    rd_data <= mem[rptr % NW];
                rptr <= rptr + 1;
            end
        end
    end

    // observe the traffic strobes away from the active edge
    always @(negedge clk) begin
        if (wr_en) begin
            wr_log.push_back(wr_data);
            wr_cyc.push_back(cyc);
        end
        if (rd_en) rd_cyc.push_back(cyc);
    end

    function automatic logic [15:0] exp_pat(input int i);
`ifdef SDRAM_BIST_PRBS_EN
        logic [15:0] s;
        s = 16'hACE1;
        for (int k = 0; k < i; k++)
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        return s;
`else
        return 16'(i);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_logs();
        wr_log.delete();
        wr_cyc.delete();
        rd_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        init_done = 1'b0;
        model_clr = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clr = 1'b0;
        clr_logs();
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (test_done) ok = 1'b1;
        end
    endtask

    typedef struct {
        int          md;
        logic        eflag;
        logic [15:0] ecnt;
        logic [15:0] efirst;
    } vec_t;

    vec_t vt [3];
    bit   ok;
    int   c0;

    initial begin
        vt[0] = '{md: 0, eflag: 1'b0, ecnt: 16'd0, efirst: 16'd0};
        vt[1] = '{md: 1, eflag: 1'b1, ecnt: 16'd1, efirst: 16'd5};
        vt[2] = '{md: 2, eflag: 1'b1, ecnt: 16'd8, efirst: 16'd0};

        rst_n = 1'b0;
        init_done = 1'b0;
        model_clr = 1'b1;
        rd_data = 16'd0;

        for (int v = 0; v < 3; v++) begin
            do_reset();
            chk("reset_outputs",
                {wr_en, rd_en, test_done, error_flag, wr_data, err_cnt},
                32'd0);
            chk("reset_first_idx", first_err_idx, 16'd0);
            mode = vt[v].md;
            @(negedge clk);
            init_done = 1'b1;
            c0 = cyc;
            wait_done(ok);
            chk("done_timeout", ok, 1'b1);
            @(negedge clk);
            chk("test_done", test_done, 1'b1);
            chk("error_flag", error_flag, vt[v].eflag);
            chk("err_cnt", err_cnt, vt[v].ecnt);
            chk("first_err_idx", first_err_idx, vt[v].efirst);
            chk("done_idle", {wr_en, rd_en}, 2'b00);
            chk("wr_count", wr_log.size(), NW);
            chk("rd_count", rd_cyc.size(), NW);
            if (wr_cyc.size() == NW && rd_cyc.size() == NW) begin
                chk("first_wr_edge", wr_cyc[0] - c0, 4);
                chk("wr_contig", wr_cyc[NW-1] - wr_cyc[0], NW - 1);
                chk("rd_contig", rd_cyc[NW-1] - rd_cyc[0], NW - 1);
                chk("rd_gap", rd_cyc[0] - wr_cyc[NW-1], DLY + 1);
                if (v == 0)
                    for (int i = 0; i < NW; i++)
                        chk($sformatf("wr_data_%0d", i), wr_log[i], exp_pat(i));
            end
`ifdef SDRAM_BIST_PRBS_EN
            if (wr_log.size() >= 2) begin
                chk("prbs_w0", wr_log[0], 16'hACE1);
                chk("prbs_w1", wr_log[1], 16'h59C3);
            end
`endif
        end

        // drop init during the write phase, then restart
        do_reset();
        mode = 1;
        @(negedge clk);
        init_done = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (wr_log.size() >= 4) ok = 1'b1;
        end
        chk("abort_wr_seen", ok, 1'b1);
        init_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_wr_low", wr_en, 1'b0);
        repeat (10) @(negedge clk);
        chk("abort_idle", {wr_en, rd_en, test_done}, 3'b000);
        model_clr = 1'b1;
        @(negedge clk);
        model_clr = 1'b0;
        clr_logs();
        mode = 0;
        init_done = 1'b1;
        wait_done(ok);
        chk("restart_done", ok, 1'b1);
        @(negedge clk);
        chk("restart_w0", (wr_log.size() > 0) ? wr_log[0] : 16'h1234,
            exp_pat(0));
        chk("restart_count", wr_log.size(), NW);
        chk("restart_err", {error_flag, err_cnt}, 17'd0);

        // reset pulse mid-read with every word corrupted
        do_reset();
        mode = 2;
        @(negedge clk);
        init_done = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (rd_cyc.size() >= 3) ok = 1'b1;
        end
        chk("rst_rd_seen", ok, 1'b1);
        chk("rst_pre_err", error_flag, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_rd",
            {wr_en, rd_en, test_done, error_flag, wr_data, err_cnt},
            32'd0);
        chk("rst_mid_first", first_err_idx, 16'd0);
        rst_n = 1'b1;
        mode = 0;
        model_clr = 1'b1;
        @(negedge clk);
        model_clr = 1'b0;
        clr_logs();
        wait_done(ok);
        chk("rst_pass_done", ok, 1'b1);
        @(negedge clk);
        chk("rst_pass_err", {error_flag, err_cnt}, 17'd0);
        chk("rst_pass_rd", rd_cyc.size(), NW);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
